// File: rtl/seq_det_prog_if.sv
// ---------------------------------------------------------------------------
// seq_det_prog_if
//
// Signal bundle between a serial bit source / configuration master and the
// seq_det_prog pattern detector. Clock and reset are not part of the bundle;
// they stay plain ports on the detector.
//
// Parameters (must match the detector instance):
//   MAX_LEN  maximum pattern length in bits
//   CNT_W    width of match_count
//   LEN_W    width of cfg_len (derived from MAX_LEN)
//
// Signals:
//   din_valid    master -> slave  qualifies din this cycle
//   din          master -> slave  serial data bit
//   cfg_load     master -> slave  load configuration this cycle
//   cfg_pattern  master -> slave  pattern, bit [len-1] is received first
//   cfg_len      master -> slave  pattern length, legal 1..MAX_LEN
//   cfg_overlap  master -> slave  1 = overlapping matches allowed
//   armed        slave -> master  a valid configuration is held
//   match        slave -> master  registered one-cycle hit pulse
//   cfg_err      slave -> master  one-cycle pulse after an illegal load
//   match_count  slave -> master  saturating hit count
//
// Modports: master (source side), slave (detector side).
// ---------------------------------------------------------------------------
interface seq_det_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
);
    logic               din_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               armed;
    logic               match;
    logic               cfg_err;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  armed, match, cfg_err, match_count
    );

    modport slave (
        input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output armed, match, cfg_err, match_count
    );
endinterface

// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
//
// Runtime-programmable serial pattern detector. A qualified serial bit
// stream is shifted into a history register and compared against a loaded
// pattern of 1..MAX_LEN bits. Every hit gives a registered one-cycle match
// pulse. Overlapping or non-overlapping detection is chosen at load time.
//
// Optional feature macro: SEQ_DET_PROG_COUNT_EN
//   defined   -> a saturating match counter drives match_count
//   undefined -> no counter flops; match_count is tied to zero
//
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    seq_det_prog_if.slave (serial input, configuration, status)
//
// States:
//   UNCFG   no valid configuration, input ignored
//   FILL    fewer than len bits collected since arming / last disjoint hit
//   DETECT  history holds at least len fresh bits
// ---------------------------------------------------------------------------
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic            clock,
    input  logic            reset,
    seq_det_prog_if.slave   bus
);

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;

    logic               load_ok;     // cfg_load with a legal length
    logic               accept;      // din taken into the history this cycle
    logic               hit;         // accepted bit completes the pattern
    logic [MAX_LEN-1:0] hist_shift;  // history including the incoming bit
    logic [MAX_LEN-1:0] len_mask;    // ones in the low len_q positions
    logic [LEN_W:0]     fill_inc;    // one bit wider so len_q == MAX_LEN compares cleanly

    // Length mask: only the low len_q bits of history and pattern take part
    // in the comparison, so pattern bits above len are don't-care.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // NOTE: every signal written here gets a default at the top, so no path
    // through the branches can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        load_ok    = bus.cfg_load && (bus.cfg_len != '0) &&
                     (bus.cfg_len <= LEN_W'(MAX_LEN));
        // A load in the same cycle wins: the din bit is dropped either way.
        accept     = bus.din_valid && !bus.cfg_load && (state_q != UNCFG);
        hist_shift = {hist_q[MAX_LEN-2:0], bus.din};
        fill_inc   = {1'b0, fill_q} + (LEN_W+1)'(1);
        hit        = accept && (fill_inc >= {1'b0, len_q}) &&
                     (((hist_shift ^ pat_q) & len_mask) == '0);

        if (bus.cfg_load) begin
            if (load_ok) begin
                pat_d     = bus.cfg_pattern;
                len_d     = bus.cfg_len;
                overlap_d = bus.cfg_overlap;
                hist_d    = '0;
                fill_d    = '0;
                state_d   = FILL;
            end else begin
                // Illegal length: flag it, keep everything else as it was.
                cfg_err_d = 1'b1;
            end
        end else if (accept) begin
            hist_d = hist_shift;
            fill_d = (fill_q == len_q) ? fill_q : fill_inc[LEN_W-1:0];
            if (hit) begin
                match_d = 1'b1;
                if (!overlap_q) begin
                    // Disjoint mode: the matched bits may not seed another hit.
                    fill_d  = '0;
                    state_d = FILL;
                end else begin
                    state_d = DETECT;
                end
            end else begin
                state_d = (fill_d == len_q) ? DETECT : FILL;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= UNCFG;
            pat_q     <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // All outputs come straight from flops: no input-to-output path.
    assign bus.armed   = (state_q != UNCFG);
    assign bus.match   = match_q;
    assign bus.cfg_err = cfg_err_q;

`ifdef SEQ_DET_PROG_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    // Cleared by every legal load, saturates at all-ones.
    always_comb begin
        count_d = count_q;
        if (load_ok) begin
            count_d = '0;
        end else if (hit && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.match_count = count_q;
`else
    assign bus.match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// ---------------------------------------------------------------------------
// tb_seq_det_prog
//
// Self-checking bench for seq_det_prog. Each step pushes the expected match
// value into a scoreboard queue as the stimulus is driven; after the clock
// edge the entry is popped and compared with the registered match output.
// The counter is built narrow (CNT_W = 2) so saturation is reachable.
// Expected counts follow SEQ_DET_PROG_COUNT_EN: zero when it is undefined.
// ---------------------------------------------------------------------------
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    seq_det_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    bit exp_q[$];

    function automatic int exp_cnt(input int hits);
`ifdef SEQ_DET_PROG_COUNT_EN
        return (hits > CNT_MAX) ? CNT_MAX : hits;
`else
        return 0;
`endif
    endfunction

    // One clock cycle of stimulus; the match expectation rides the scoreboard.
    task automatic step(input bit load, input bit valid, input bit d,
                        input bit exp_match, input string tag);
        bit e;
        bus.cfg_load  = load;
        bus.din_valid = valid;
        bus.din       = d;
        exp_q.push_back(exp_match);
        @(posedge clock);
        #1;
        bus.cfg_load  = 1'b0;
        bus.din_valid = 1'b0;
        e = exp_q.pop_front();
        n_assert++;
        if (bus.match !== e) begin
            n_fail++;
            $display("FAIL %s: match=%b expected %b at %0t", tag, bus.match, e, $time);
        end
    endtask

    task automatic set_cfg(input logic [MAX_LEN-1:0] p, input int len, input bit ov);
        bus.cfg_pattern = p;
        bus.cfg_len     = LEN_W'(len);
        bus.cfg_overlap = ov;
    endtask

    task automatic test_reset();
        bus.din_valid   = 1'b0;
        bus.din         = 1'b0;
        bus.cfg_load    = 1'b0;
        set_cfg('0, 0, 1'b0);
        reset = 1'b1;
        #3;
        n_assert++;
        if (bus.armed !== 1'b0 || bus.match !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: armed=%b match=%b cfg_err=%b expected 0 0 0",
                     bus.armed, bus.match, bus.cfg_err);
        end
        n_assert++;
        if (bus.match_count !== '0) begin
            n_fail++;
            $display("FAIL reset_count: match_count=%0d expected 0", bus.match_count);
        end
        #10 reset = 1'b0;
        @(posedge clock);
        #1;
        // Unconfigured: a would-be "1011" stream must be ignored.
        step(0, 1, 1, 0, "uncfg");
        step(0, 1, 0, 0, "uncfg");
        step(0, 1, 1, 0, "uncfg");
        step(0, 1, 1, 0, "uncfg");
        n_assert++;
        if (bus.armed !== 1'b0) begin
            n_fail++;
            $display("FAIL uncfg_armed: armed=%b expected 0", bus.armed);
        end
    endtask

    task automatic run_stream(input bit s[], input bit e[], input string tag);
        for (int i = 0; i < s.size(); i++) begin
            step(0, 1, s[i], e[i], tag);
        end
    endtask

    task automatic check_count(input int hits, input string tag);
        n_assert++;
        if (bus.match_count !== CNT_W'(exp_cnt(hits))) begin
            n_fail++;
            $display("FAIL %s: match_count=%0d expected %0d", tag, bus.match_count, exp_cnt(hits));
        end
    endtask

    task automatic test_overlap();
        // Upper pattern bits set on purpose: they must be ignored for len 4.
        set_cfg(8'b1110_1011, 4, 1'b1);
        step(1, 0, 0, 0, "overlap_load");
        n_assert++;
        if (bus.armed !== 1'b1 || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap_armed: armed=%b cfg_err=%b expected 1 0", bus.armed, bus.cfg_err);
        end
        run_stream('{1, 0, 1, 1, 0, 1, 1}, '{0, 0, 0, 1, 0, 0, 1}, "overlap");
        check_count(2, "overlap_count");
    endtask

    task automatic test_non_overlap();
        set_cfg(8'b0000_1011, 4, 1'b0);
        step(1, 0, 0, 0, "nonoverlap_load");
        check_count(0, "load_clears_count");
        run_stream('{1, 0, 1, 1, 0, 1, 1}, '{0, 0, 0, 1, 0, 0, 0}, "nonoverlap");
        check_count(1, "nonoverlap_count");
    endtask

    task automatic test_gapped();
        set_cfg(8'b0000_0110, 3, 1'b1);
        step(1, 0, 0, 0, "gapped_load");
        run_stream('{1}, '{0}, "gapped");
        step(0, 0, 0, 0, "gapped_gap");
        step(0, 0, 1, 0, "gapped_gap");
        run_stream('{1}, '{0}, "gapped");
        step(0, 0, 0, 0, "gapped_gap");
        step(0, 0, 0, 0, "gapped_gap");
        run_stream('{0}, '{1}, "gapped_hit");
        step(0, 0, 0, 0, "gapped_pulse_end");
        check_count(1, "gapped_count");
    endtask

    task automatic test_illegal();
        set_cfg(8'hFF, 0, 1'b0);
        step(1, 0, 0, 0, "illegal_len0");
        n_assert++;
        if (bus.cfg_err !== 1'b1 || bus.armed !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_len0: cfg_err=%b armed=%b expected 1 1", bus.cfg_err, bus.armed);
        end
        step(0, 0, 0, 0, "illegal_gap");
        n_assert++;
        if (bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_one_cycle: cfg_err=%b expected 0", bus.cfg_err);
        end
        set_cfg(8'hFF, MAX_LEN + 1, 1'b0);
        step(1, 0, 0, 0, "illegal_len_over");
        n_assert++;
        if (bus.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_len_over: cfg_err=%b expected 1", bus.cfg_err);
        end
        check_count(1, "illegal_keeps_count");
        // Old "110" pattern still active, overlap mode.
        run_stream('{1, 1, 0}, '{0, 0, 1}, "illegal_old_pattern");
        check_count(2, "illegal_old_count");
    endtask

    task automatic test_priority();
        set_cfg(8'b0000_1011, 4, 1'b1);
        step(1, 0, 0, 0, "priority_load");
        run_stream('{1, 0, 1}, '{0, 0, 0}, "priority_prefix");
        // Completing bit arrives with a load: dropped, history cleared.
        step(1, 1, 1, 0, "priority_collide");
        run_stream('{0, 1, 1, 0, 1, 1}, '{0, 0, 0, 0, 0, 1}, "priority_after");
        check_count(1, "priority_count");
    endtask

    task automatic test_full_len();
        set_cfg(8'b1001_0110, MAX_LEN, 1'b0);
        step(1, 0, 0, 0, "full_len_load");
        run_stream('{1, 0, 0, 1, 0, 1, 1, 0}, '{0, 0, 0, 0, 0, 0, 0, 1}, "full_len");
        check_count(1, "full_len_count");
    endtask

    task automatic test_back_to_back();
        set_cfg(8'b0000_0001, 1, 1'b1);
        step(1, 0, 0, 0, "b2b_load");
        check_count(0, "b2b_count_start");
        run_stream('{1, 1, 1, 1, 1, 1, 0}, '{1, 1, 1, 1, 1, 1, 0}, "b2b");
        check_count(6, "b2b_saturate");
    endtask

    task automatic test_async_reset();
        set_cfg(8'b0000_1011, 4, 1'b1);
        step(1, 0, 0, 0, "areset_load");
        run_stream('{1, 0, 1, 1}, '{0, 0, 0, 1}, "areset_hit");
        // Assert between edges while the match pulse is still high.
        #2 reset = 1'b1;
        #1;
        n_assert++;
        if (bus.match !== 1'b0 || bus.armed !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: match=%b armed=%b cfg_err=%b expected 0 0 0",
                     bus.match, bus.armed, bus.cfg_err);
        end
        check_count(0, "areset_count");
        @(posedge clock);
        #3 reset = 1'b0;
        run_stream('{1, 0, 1, 1, 1}, '{0, 0, 0, 0, 0}, "areset_ignored");
        n_assert++;
        if (bus.armed !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_armed: armed=%b expected 0", bus.armed);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gapped();
        test_illegal();
        test_priority();
        test_full_len();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/seq_det_prog.md
# seq_det_prog

Runtime-programmable serial pattern detector, the parametrised successor to the fixed 4-state "1011" detector. It compares a qualified serial bit stream against a loadable pattern of 1..MAX_LEN bits, in overlapping or non-overlapping mode. Each hit produces a registered one-cycle match pulse, plus an optional saturating hit counter. It sits on a serial receive path, after bit recovery, as a reusable detector for sync words and markers.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits (2..32).
- CNT_W, 8: width of match_count (1..32).
- LEN_W, $clog2(MAX_LEN)+1: width of cfg_len (derived; do not override).

Ports:
- clock  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- din_valid  input  1  qualifies din this cycle.
- din  input  1  serial data bit.
- cfg_load  input  1  load configuration this cycle.
- cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] is the last.
- cfg_len  input  LEN_W  pattern length, legal range 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping matches; 0 = non-overlapping.
- armed  output  1  high when a valid configuration is held.
- match  output  1  one-cycle pulse, registered.
- cfg_err  output  1  one-cycle pulse when cfg_load carries an illegal length.
- match_count  output  CNT_W  saturating count of matches.

## Operation
- **State machine**: UNCFG -> FILL <-> DETECT.
  - UNCFG: entered on reset. No detection.
  - FILL: fewer than len bits have been accepted since arming or since the last non-overlap match.
  - DETECT: fill_cnt == len.
- **cfg_load with legal cfg_len**:
  - Latches pattern, len and overlap.
  - Clears the history shift register, fill_cnt and match_count.
  - Next state FILL; armed = 1.
- **cfg_load with cfg_len == 0 or > MAX_LEN**:
  - cfg_err pulses next cycle.
  - All state and configuration are unchanged.
- **cfg_load priority**: cfg_load beats din_valid in the same cycle. That din bit is discarded, and no match is generated from it.
- **Accepted bit** (din_valid = 1, armed, no cfg_load):
  - hist <= {hist[MAX_LEN-2:0], din}.
  - fill_cnt increments, saturating at len.
- **Hit condition**: fill_cnt+1 >= len, and the low len bits of the new hist equal the low len bits of the pattern. Pattern bits at [MAX_LEN-1:len] are ignored.
- **On a hit**:
  - match <= 1 for one cycle.
  - match_count increments, saturating at 2^CNT_W-1.
  - Non-overlap mode: fill_cnt <= 0 and state FILL. Bits of the matched pattern cannot be reused.
  - Overlap mode: state stays DETECT.
- **din_valid = 0**: no state change, and match <= 0.
- **UNCFG**: din is ignored entirely.

## Timing
- **Reset values** (asynchronous, immediate): state UNCFG, armed 0, match 0, cfg_err 0, match_count 0, hist 0, fill_cnt 0.
- **Match latency**: match is high in the cycle after the clock edge that accepted the final pattern bit.
- **Back-to-back**: with len = 1 in overlap mode, consecutive accepted hits give consecutive match cycles.
- **armed**: rises in the cycle after a legal cfg_load.
- **cfg_err**: high for exactly one cycle after an illegal load.
- **Reset mid-stream**: all outputs clear at once. A match pending from the prior edge is lost.
- **No combinational path** from any input to any output.

## Configuration
- **Macro**: SEQ_DET_PROG_COUNT_EN.
- **Defined**: the match_count register and saturating increment are built as described above.
- **Undefined**: no counter flops are built. The match_count port remains and is tied to 0, so the interface stays identical. All other behaviour is unchanged.

## Test plan
- **Overlap, "1011"**: cfg_pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 (all valid) -> match after bits 4 and 7; match_count=2.
- **Non-overlap, same stream**: overlap=0 -> single match after bit 4; match_count=1.
- **Gapped input**: len=3, pattern 3'b110; stream 1,1,0 with din_valid low for 2 cycles between each bit -> one match, one cycle after the 0 is accepted; no match during gaps.
- **Illegal and priority loads**:
  - cfg_len=0 while armed -> cfg_err pulse; armed stays 1; detection continues with the old pattern.
  - cfg_load in the same cycle as a completing bit -> no match.
- **Counter saturation**: CNT_W=2, len=1, pattern 1, overlap=1, six consecutive 1s -> six match pulses; match_count stops at 3. With macro undefined -> match_count stays 0.
- **Asynchronous reset**: assert reset between edges mid-pattern -> outputs clear immediately; armed=0; subsequent din ignored until cfg_load.
